pattern_frame_sequencer: RTL

- Controller that sequences the test-pattern pixel datapath over the AXI-Stream-style video link.
- Produces registered pixel coordinates, frame/line markers (o_start = SOF, o_last = EOL) and the active pattern index, qualified by a valid/ready handshake.
- Frame start/stop is governed by i_enable. Inserts a programmable inter-frame gap. Rotates through test patterns, either automatically or under host selection.
- Sits between the control register block and the colour generator; the colour generator maps (o_x, o_y, o_pattern) to 24-bit RGB.

---
 rtl/pattern_frame_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pattern_frame_sequencer.sv
// rtl/pattern_frame_sequencer.sv - test-pattern frame sequencer: pixel coordinates, SOF/EOL markers and pattern index
// with a valid/ready handshake, inter-frame gap and auto/manual pattern rotation.
module pattern_frame_sequencer #(
    parameter int H_ACTIVE           = 1280,
    parameter int V_ACTIVE           = 720,
    parameter int FRAME_GAP          = 16,
    parameter int FRAMES_PER_PATTERN = 60,
    parameter int NUM_PATTERNS       = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_enable,
    input  logic        i_ready,
    input  logic        i_auto,
    input  logic [1:0]  i_pattern_sel,
    output logic        o_valid,
    output logic        o_start,
    output logic        o_last,
    output logic [10:0] o_x,
    output logic [9:0]  o_y,
    output logic [1:0]  o_pattern,
    output logic        o_frame_done,
    output logic        o_busy
);

    localparam int CW = $clog2(FRAMES_PER_PATTERN + 1);
    localparam int GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [10:0]   X_MAX    = 11'(H_ACTIVE - 1);
    localparam logic [9:0]    Y_MAX    = 10'(V_ACTIVE - 1);
    localparam logic [1:0]    PAT_MAX  = 2'(NUM_PATTERNS - 1);
    localparam logic [CW-1:0] FPP      = CW'(FRAMES_PER_PATTERN);
    localparam logic [GW-1:0] GAP_LAST = GW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [10:0]   x_q, x_d;
    logic [9:0]    y_q, y_d;
    logic [1:0]    pat_q, pat_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_end;
    logic [GW-1:0] gap_q, gap_d;
    logic          valid_q, valid_d;
    logic          start_q, start_d;
    logic          last_q, last_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;
    logic          accept, frame_end, frame_start;

    assign accept    = valid_q && i_ready;
    assign frame_end = accept && (x_q == X_MAX) && (y_q == Y_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (i_enable) state_d = S_ACTIVE;
            S_ACTIVE: begin
                if (frame_end) begin
                    if (FRAME_GAP > 0)  state_d = S_GAP;
                    else if (!i_enable) state_d = S_IDLE;
                end
            end
            S_GAP:    if (gap_q == GAP_LAST) state_d = i_enable ? S_ACTIVE : S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // A frame starts on any entry into ACTIVE, or on a back-to-back frame end that stays ACTIVE.
    always_comb begin
        frame_start = (state_d == S_ACTIVE) && ((state_q != S_ACTIVE) || frame_end);
        cnt_end     = (cnt_q == FPP) ? cnt_q : cnt_q + CW'(1);
        x_d    = x_q;
        y_d    = y_q;
        pat_d  = pat_q;
        cnt_d  = cnt_q;
        gap_d  = gap_q;
        done_d = 1'b0;
        if (state_q == S_GAP) gap_d = gap_q + GW'(1);
        if (accept) begin
            if (x_q != X_MAX) begin
                x_d = x_q + 11'd1;
            end else begin
                x_d = '0;
                y_d = (y_q != Y_MAX) ? y_q + 10'd1 : '0;
            end
        end
        if (frame_end) begin
            done_d = 1'b1;
            cnt_d  = cnt_end;
            gap_d  = '0;
        end
        if (frame_start) begin
            x_d = '0;
            y_d = '0;
            if (!i_auto) begin
                pat_d = (i_pattern_sel > PAT_MAX) ? PAT_MAX : i_pattern_sel;
                cnt_d = '0;
            end else if (cnt_d == FPP) begin
                cnt_d = '0;
                pat_d = (pat_q == PAT_MAX) ? 2'd0 : pat_q + 2'd1;
            end
        end
        valid_d = (state_d == S_ACTIVE);
        start_d = valid_d && (x_d == 11'd0) && (y_d == 10'd0);
        last_d  = valid_d && (x_d == X_MAX);
        busy_d  = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q     <= '0;
            y_q     <= '0;
            pat_q   <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            pat_q   <= pat_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            valid_q <= valid_d;
            start_q <= start_d;
            last_q  <= last_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_start      = start_q;
    assign o_last       = last_q;
    assign o_x          = x_q;
    assign o_y          = y_q;
    assign o_pattern    = pat_q;
    assign o_frame_done = done_q;
    assign o_busy       = busy_q;

endmodule
